// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin, quantum-limited arbiter steering one 2:1 data mux between two valid/ready requesters
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid0/1, in_data0/1   requester beats
//   in_ready0/1               beat accepted from that requester this cycle
//   out_valid, out_data       muxed beat (data forced to 0 when not valid)
//   out_ready                 downstream accepts the beat
//   grant                     one-hot grant, 00 when idle
//   sel                       mux select, held while idle
module mux2_rr_arbiter #(
    parameter int DATA_W  = 8,
    parameter int QUANTUM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid0,
    input  logic [DATA_W-1:0] in_data0,
    output logic              in_ready0,
    input  logic              in_valid1,
    input  logic [DATA_W-1:0] in_data1,
    output logic              in_ready1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        grant,
    output logic              sel
);
    localparam int CW = $clog2(QUANTUM + 1);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t        state;
    logic          last;
    logic [CW-1:0] cnt;
    logic          cur, vx, vy, fire, quota;
    assign grant     = {state == GNT1, state == GNT0};
    assign out_valid = (grant[0] & in_valid0) | (grant[1] & in_valid1);
    assign out_data  = out_valid ? (sel ? in_data1 : in_data0) : '0;
    assign in_ready0 = grant[0] & out_ready;
    assign in_ready1 = grant[1] & out_ready;
    assign fire      = out_valid & out_ready;
    assign cur       = state == GNT1;
    assign vx        = cur ? in_valid1 : in_valid0;
    assign vy        = cur ? in_valid0 : in_valid1;
    // >= rather than == so a quantum that saturated while the other side was
    // silent still hands over on the first fire after it raises valid
    assign quota     = cnt >= CW'(QUANTUM - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            sel   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (in_valid0 & (~in_valid1 | last)) begin
                        state <= GNT0;
                        sel   <= 1'b0;
                    end else if (in_valid1) begin
                        state <= GNT1;
                        sel   <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    // a stalled beat (vx & !fire) falls through and holds everything
                    if (~vx | (fire & quota & vy)) begin
                        last <= cur;
                        cnt  <= '0;
                        if (vy) begin
                            state <= cur ? GNT0 : GNT1;
                            sel   <= ~cur;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (fire && cnt != CW'(QUANTUM)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed scenarios plus random traffic checked against a behavioural owner/beat model
module tb_mux2_rr_arbiter;
    localparam int DW = 8;
    localparam int Q  = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid0 = 1'b1, in_valid1 = 1'b1, out_ready = 1'b1;
    logic [DW-1:0] in_data0 = '0, in_data1 = '0;
    logic          in_ready0, in_ready1, out_valid, sel;
    logic [DW-1:0] out_data;
    logic [1:0]    grant;
    int checks = 0, failures = 0;
    int owner = -1, last = 1, beats = 0, msel = 0;
    mux2_rr_arbiter #(.DATA_W(DW), .QUANTUM(Q)) dut (
        .clk(clk), .rst(rst),
        .in_valid0(in_valid0), .in_data0(in_data0), .in_ready0(in_ready0),
        .in_valid1(in_valid1), .in_data1(in_data1), .in_ready1(in_ready1),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant(grant), .sel(sel)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic exp_valid();
        return owner == 0 ? in_valid0 : owner == 1 ? in_valid1 : 1'b0;
    endfunction
    task automatic compare_model();
        logic ev;
        ev = exp_valid();
        check("grant", grant, owner == 0 ? 1 : owner == 1 ? 2 : 0);
        check("out_valid", out_valid, ev);
        check("out_data", out_data, ev ? (owner == 1 ? in_data1 : in_data0) : 0);
        check("in_ready0", in_ready0, owner == 0 && out_ready);
        check("in_ready1", in_ready1, owner == 1 && out_ready);
        check("sel", sel, msel);
        check("ready_excl", in_ready0 & in_ready1, 0);
    endtask
    task automatic update_model();
        int x;
        logic vx, vy;
        if (rst) begin
            owner = -1; last = 1; beats = 0; msel = 0;
        end else if (owner < 0) begin
            beats = 0;
            if (in_valid0 && in_valid1) owner = 1 - last;
            else if (in_valid0) owner = 0;
            else if (in_valid1) owner = 1;
            if (owner >= 0) msel = owner;
        end else begin
            x  = owner;
            vx = x == 1 ? in_valid1 : in_valid0;
            vy = x == 1 ? in_valid0 : in_valid1;
            if (!vx) begin
                last = x; beats = 0;
                owner = vy ? 1 - x : -1;
                if (vy) msel = owner;
            end else if (out_ready) begin
                beats++;
                if (beats >= Q && vy) begin
                    last = x; beats = 0; owner = 1 - x; msel = owner;
                end
            end
        end
    endtask
    task automatic step(input logic r, input logic a, input logic [DW-1:0] da,
                        input logic b, input logic [DW-1:0] db, input logic o);
        @(negedge clk);
        rst = r; in_valid0 = a; in_data0 = da; in_valid1 = b; in_data1 = db; out_ready = o;
        #1 compare_model();
        @(posedge clk);
        update_model();
    endtask
    initial begin
        @(posedge clk);
        update_model();
        // only requester 0 valid after reset
        step(1, 0, 8'h00, 0, 8'h00, 1);
        step(0, 1, 8'hA5, 0, 8'h3C, 1);
        #1;
        check("t2_grant", grant, 2'b01);
        check("t2_data", out_data, 8'hA5);
        check("t2_ready0", in_ready0, 1);
        check("t2_ready1", in_ready1, 0);
        // reset with both valids high
        step(1, 1, 8'h11, 1, 8'h22, 1);
        step(1, 1, 8'h11, 1, 8'h22, 1);
        #1;
        check("t1_grant", grant, 0);
        check("t1_valid", out_valid, 0);
        check("t1_data", out_data, 0);
        step(0, 1, 8'h11, 1, 8'h22, 1);
        // continuous contention: 01x4, 10x4, 01x4 with no idle cycle
        for (int i = 0; i < 12; i++) begin
            #1 check("t3_grant", grant, i / 4 == 1 ? 2 : 1);
            step(0, 1, 8'(i), 1, 8'(i + 100), 1);
        end
        // GNT1, two beats in, then a three-cycle stall
        step(0, 1, 8'h31, 1, 8'h41, 1);
        step(0, 1, 8'h32, 1, 8'h42, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h33, 1, 8'h43, 0);
            #1;
            check("t4_grant", grant, 2'b10);
            check("t4_valid", out_valid, 1);
            check("t4_ready1", in_ready1, 0);
        end
        step(0, 1, 8'h34, 1, 8'h44, 1);
        #1 check("t4_hold", grant, 2'b10);
        step(0, 1, 8'h35, 1, 8'h45, 1);
        #1 check("t4_switch", grant, 2'b01);
        // requester 0 withdraws, then both withdraw
        step(0, 0, 8'h00, 1, 8'h51, 1);
        #1;
        check("t5_grant", grant, 2'b10);
        check("t5_sel", sel, 1);
        step(0, 0, 8'h00, 0, 8'h00, 1);
        #1;
        check("t5_idle", grant, 0);
        check("t5_selheld", sel, 1);
        // reset mid-burst in GNT1
        step(0, 0, 8'h00, 1, 8'h61, 1);
        step(0, 0, 8'h00, 1, 8'h62, 1);
        step(0, 0, 8'h00, 1, 8'h63, 1);
        step(1, 1, 8'h71, 1, 8'h72, 1);
        #1 check("t6_idle", grant, 0);
        step(0, 1, 8'h73, 1, 8'h74, 1);
        #1 check("t6_grant", grant, 2'b01);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
